// File: rtl/regfile_32x64_if.sv
// Register-file access bundle: writeback write request plus the two decode-stage read ports.
// The master drives requests and addresses, and the slave (register file) returns read data.
interface regfile_32x64_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) ();
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_32x64.sv
// LEGv8 integer register file: 31 writable registers plus hardwired-zero XZR, with two async read ports.
// Optional macro REGFILE_WRITE_BYPASS_EN adds a same-cycle write-through path on both read ports.
module regfile_32x64 #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_IDX = 31
) (
    input  logic           clk,
    input  logic           reset,
    regfile_32x64_if.slave rf
);
    localparam int NREG = 2 ** ADDR_W;
    localparam int NGRP = NREG / 8;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_IDX[ADDR_W-1:0];

    logic [NGRP-1:0]  grp_en;
    logic [NREG-1:0]  wren;
    logic             unused_xzr_wren;
    // XZR has no storage, so only NREG-1 physical registers exist.
    logic [WIDTH-1:0] regs_q [NREG-1];
    logic [WIDTH-1:0] regs_d [NREG-1];

    // Predecode the upper address bits into group enables, each gating one 3-to-8 decoder.
    always_comb begin
        grp_en = '0;
        if (rf.RegWrite) begin
            grp_en[rf.WriteRegister[ADDR_W-1:3]] = 1'b1;
        end
    end

    always_comb begin
        wren = '0;
        for (int g = 0; g < NGRP; g++) begin
            wren[g*8 +: 8] = grp_en[g] ? (8'b1 << rf.WriteRegister[2:0]) : 8'b0;
        end
    end

    assign unused_xzr_wren = wren[ZERO_IDX];

    always_comb begin
        for (int i = 0; i < NREG - 1; i++) begin
            regs_d[i] = wren[i] ? rf.WriteData : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [WIDTH-1:0] rd;
        rd = (ra == ZERO_ADDR) ? '0 : regs_q[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Write-through removes the WB-to-ID hazard; held off during reset so reads show cleared state.
        if (!reset && rf.RegWrite && (rf.WriteRegister == ra) && (ra != ZERO_ADDR)) begin
            rd = rf.WriteData;
        end
`endif
        return rd;
    endfunction

    always_comb begin
        rf.ReadData1 = read_port(rf.ReadRegister1);
        rf.ReadData2 = read_port(rf.ReadRegister2);
    end
endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed spec scenarios followed by random traffic
// compared against an array-based reference model (honours REGFILE_WRITE_BYPASS_EN if defined).
module tb_regfile_32x64;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] model [32];

    regfile_32x64_if #(.WIDTH(64), .ADDR_W(5)) rf_if ();

    regfile_32x64 #(.WIDTH(64), .ADDR_W(5), .ZERO_IDX(31)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value given current model contents and the inputs presented this cycle.
    function automatic logic [63:0] exp_read(input logic [4:0] ra);
        if (ra == 5'd31) return 64'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!reset && rf_if.RegWrite && rf_if.WriteRegister == ra) return rf_if.WriteData;
`endif
        return model[ra];
    endfunction

    // Advance one clock edge and apply the architectural effect of the current inputs to the model.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (rf_if.RegWrite && rf_if.WriteRegister != 5'd31) begin
            model[rf_if.WriteRegister] = rf_if.WriteData;
        end
        #1;
    endtask

    task automatic drive_wr(input logic we, input logic [4:0] wa, input logic [63:0] wd);
        rf_if.RegWrite      = we;
        rf_if.WriteRegister = wa;
        rf_if.WriteData     = wd;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b, input string tag);
        rf_if.ReadRegister1 = a;
        rf_if.ReadRegister2 = b;
        #1;
        check($sformatf("%s_rd1[%0d]", tag, a), rf_if.ReadData1, exp_read(a));
        check($sformatf("%s_rd2[%0d]", tag, b), rf_if.ReadData2, exp_read(b));
    endtask

    initial begin
        logic [4:0]  ra1, ra2;
        logic [63:0] e1, e2;
        for (int i = 0; i < 32; i++) model[i] = 'x;
        reset = 1'b1;
        drive_wr(1'b0, 5'd0, 64'h0);
        rf_if.ReadRegister1 = 5'd0;
        rf_if.ReadRegister2 = 5'd0;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), "init_reset");

        // Reset clears a previously written register.
        drive_wr(1'b1, 5'd5, 64'hDEAD_BEEF);
        step();
        drive_wr(1'b0, 5'd0, 64'h0);
        read_pair(5'd5, 5'd5, "pre_reset");
        check("x5_before_reset", rf_if.ReadData1, 64'hDEAD_BEEF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        read_pair(5'd5, 5'd0, "post_reset");
        check("x5_after_reset", rf_if.ReadData1, 64'h0);
        for (int i = 0; i < 32; i++) begin
            rf_if.ReadRegister1 = 5'(i);
            #1;
            check($sformatf("reset_zero[%0d]", i), rf_if.ReadData1, 64'h0);
        end

        // Fill X0..X30 and read back as (i, 30-i) pairs.
        for (int i = 0; i < 31; i++) begin
            drive_wr(1'b1, 5'(i), 64'h1111_0000_0000_0000 + 64'(i));
            step();
        end
        drive_wr(1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 31; i++) begin
            read_pair(5'(i), 5'(30 - i), "fill");
            check($sformatf("fill_const[%0d]", i), rf_if.ReadData1, 64'h1111_0000_0000_0000 + 64'(i));
        end
        read_pair(5'd31, 5'd31, "x31_fill");

        // Writes to XZR are discarded.
        drive_wr(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        read_pair(5'd31, 5'd31, "xzr_pre");
        step();
        drive_wr(1'b0, 5'd0, 64'h0);
        read_pair(5'd31, 5'd31, "xzr_post");
        check("xzr_rd1_zero", rf_if.ReadData1, 64'h0);
        check("xzr_rd2_zero", rf_if.ReadData2, 64'h0);
        for (int i = 0; i < 31; i++) begin
            rf_if.ReadRegister1 = 5'(i);
            #1;
            check($sformatf("xzr_no_side[%0d]", i), rf_if.ReadData1, 64'h1111_0000_0000_0000 + 64'(i));
        end

        // RegWrite=0 leaves X7 untouched.
        drive_wr(1'b1, 5'd7, 64'hAAAA);
        step();
        drive_wr(1'b0, 5'd7, 64'h1234);
        step();
        read_pair(5'd7, 5'd7, "wr_disable");
        check("x7_held", rf_if.ReadData1, 64'hAAAA);

        // Same-cycle read and write of X9.
        drive_wr(1'b1, 5'd9, 64'h1);
        step();
        drive_wr(1'b1, 5'd9, 64'h2);
        rf_if.ReadRegister2 = 5'd9;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("x9_same_cycle", rf_if.ReadData2, 64'h2);
`else
        check("x9_same_cycle", rf_if.ReadData2, 64'h1);
`endif
        step();
        drive_wr(1'b0, 5'd0, 64'h0);
        #1;
        check("x9_after_edge", rf_if.ReadData2, 64'h2);

        // Reset beats a simultaneous write; bypass must stay off during reset.
        reset = 1'b1;
        drive_wr(1'b1, 5'd3, 64'h55);
        rf_if.ReadRegister1 = 5'd3;
        #1;
        check("x3_during_reset", rf_if.ReadData1, 64'h1111_0000_0000_0003);
        step();
        reset = 1'b0;
        drive_wr(1'b0, 5'd0, 64'h0);
        #1;
        check("x3_reset_wins", rf_if.ReadData1, 64'h0);

        // Random traffic against the model, checked before and after each edge.
        for (int n = 0; n < 300; n++) begin
            drive_wr(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom});
            ra1 = ($urandom_range(0, 3) == 0) ? rf_if.WriteRegister : 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            rf_if.ReadRegister1 = ra1;
            rf_if.ReadRegister2 = ra2;
            #1;
            e1 = exp_read(ra1);
            e2 = exp_read(ra2);
            check("rand_pre_rd1", rf_if.ReadData1, e1);
            check("rand_pre_rd2", rf_if.ReadData2, e2);
            step();
            drive_wr(1'b0, 5'd0, 64'h0);
            #1;
            check("rand_post_rd1", rf_if.ReadData1, model[ra1] & {64{ra1 != 5'd31}});
            check("rand_post_rd2", rf_if.ReadData2, exp_read(ra2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
